// File: rtl/rr_arbiter_8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter.
//   ST_IDLE / ST_GRANT : FSM state encodings
//   NUM_REQ            : number of requesters
//   IDX_W              : width of a requester index
package arb_defs;
    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;
    localparam int   NUM_REQ  = 8;
    localparam int   IDX_W    = 3;
endpackage

// File: rtl/rr_arbiter_8_decoder.sv
// 3-to-8 one-hot decoder.
//   sel : input  [2:0] binary index
//   dec : output [7:0] one-hot form of sel
module decoder_3_8 (
    input  logic [2:0] sel,
    output logic [7:0] dec
);
    always_comb begin
        dec      = 8'h00;
        dec[sel] = 1'b1;
    end
endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter sharing one resource between 8 requesters. A grant is
// held until the owner drops its request or, when MAX_HOLD != 0, until the
// grant has lasted MAX_HOLD cycles. One idle cycle separates grants.
//   clk       : input       system clock, rising edge
//   rst       : input       synchronous active-high reset
//   req       : input  [7:0] request vector, bit i = requester i
//   gnt       : output [7:0] one-hot grant, zero when no grant is active
//   gnt_idx   : output [2:0] index of the current or most recent winner
//   gnt_valid : output       high while a grant is active
//   timeout   : output       one-cycle pulse after a grant is revoked by MAX_HOLD
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no grant; arbitrate req from ptr on the next edge
// ST_GRANT | gnt_idx owns the resource; hold_cnt counts grant cycles
module rr_arbiter_8
    import arb_defs::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid,
    output logic               timeout
);
    // Count value seen on the last allowed grant cycle.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    logic             state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_q, to_d;
    logic [NUM_REQ-1:0] dec_out;

    // First set bit of r in the search order p, p+1, ..., p+7 (mod 8).
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [IDX_W-1:0]   p);
        logic [IDX_W-1:0] cand;
        logic [IDX_W-1:0] pick;
        logic             found;
        pick  = p;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = p + IDX_W'(i);
            if (!found && r[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        to_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (|req) begin
                    idx_d   = rr_pick(req, ptr_q);
                    state_d = ST_GRANT;
                end
            end
            default: begin
                if (!req[idx_q] || (MAX_HOLD != 0 && cnt_q == HOLD_LAST)) begin
                    // Release and timeout share the same exit; only the
                    // timeout case flags the pulse.
                    state_d = ST_IDLE;
                    ptr_d   = idx_q + IDX_W'(1);
                    cnt_d   = '0;
                    to_d    = req[idx_q];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    decoder_3_8 u_dec (
        .sel (idx_q),
        .dec (dec_out)
    );

    always_comb begin
        gnt_valid = (state_q == ST_GRANT);
        gnt       = gnt_valid ? dec_out : '0;
        gnt_idx   = idx_q;
        timeout   = to_q;
    end
endmodule

// File: tb/tb_rr_arbiter_8.sv
module tb_rr_arbiter_8;
    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic [7:0] req_a, req_b;
    logic [7:0] gnt_a, gnt_b;
    logic [2:0] idx_a, idx_b;
    logic       val_a, val_b;
    logic       to_a, to_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Timeout at 4 cycles.
    rr_arbiter_8 #(.MAX_HOLD(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst_a), .req(req_a),
        .gnt(gnt_a), .gnt_idx(idx_a), .gnt_valid(val_a), .timeout(to_a)
    );

    // Timeout disabled.
    rr_arbiter_8 #(.MAX_HOLD(0), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst_b), .req(req_b),
        .gnt(gnt_b), .gnt_idx(idx_b), .gnt_valid(val_b), .timeout(to_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [7:0] g, input logic [2:0] i,
                         input logic v, input logic t);
        chk({tag, ".gnt"}, 32'(gnt_a), 32'(g));
        chk({tag, ".idx"}, 32'(idx_a), 32'(i));
        chk({tag, ".valid"}, 32'(val_a), 32'(v));
        chk({tag, ".timeout"}, 32'(to_a), 32'(t));
    endtask

    initial begin
        logic [7:0] e;
        rst_a = 1'b1; rst_b = 1'b1; req_a = 8'h00; req_b = 8'h00;
        tick(); tick();
        rst_a = 1'b0; rst_b = 1'b0;
        chk_a("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        chk("reset_b.gnt", 32'(gnt_b), 32'h0);
        chk("reset_b.valid", 32'(val_b), 32'h0);

        // No requests: nothing happens.
        for (int c = 0; c < 10; c++) begin
            tick();
            chk_a("idle", 8'h00, 3'd0, 1'b0, 1'b0);
        end

        // Single requester 2, held 3 cycles then dropped.
        req_a = 8'h04;
        tick(); chk_a("single.c1", 8'h04, 3'd2, 1'b1, 1'b0);
        tick(); chk_a("single.c2", 8'h04, 3'd2, 1'b1, 1'b0);
        tick(); chk_a("single.c3", 8'h04, 3'd2, 1'b1, 1'b0);
        req_a = 8'h00;
        tick(); chk_a("single.rel", 8'h00, 3'd2, 1'b0, 1'b0);
        // ptr is now 3: requester 3 beats requester 0.
        req_a = 8'h09;
        tick(); chk_a("ptr3", 8'h08, 3'd3, 1'b1, 1'b0);
        req_a = 8'h00;
        tick(); chk_a("ptr3.rel", 8'h00, 3'd3, 1'b0, 1'b0);

        // All requesting, timeout after 4 cycles each, ptr from 0.
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        chk_a("rst2", 8'h00, 3'd0, 1'b0, 1'b0);
        req_a = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            e = 8'h01 << (g % 8);
            for (int c = 0; c < 4; c++) begin
                tick();
                chk_a($sformatf("rr.g%0d.c%0d", g, c), e, 3'(g % 8), 1'b1, 1'b0);
            end
            tick();
            chk_a($sformatf("rr.g%0d.gap", g), 8'h00, 3'(g % 8), 1'b0, 1'b1);
        end

        // Grant 5 moves ptr to 6; then 6 beats 0, and 0 follows.
        req_a = 8'h20;
        tick(); chk_a("p5", 8'h20, 3'd5, 1'b1, 1'b0);
        req_a = 8'h00;
        tick(); chk_a("p5.rel", 8'h00, 3'd5, 1'b0, 1'b0);
        req_a = 8'h41;
        tick(); chk_a("p6.win", 8'h40, 3'd6, 1'b1, 1'b0);
        req_a = 8'h01;
        tick(); chk_a("p6.rel", 8'h00, 3'd6, 1'b0, 1'b0);
        tick(); chk_a("p0.win", 8'h01, 3'd0, 1'b1, 1'b0);
        req_a = 8'h21;
        tick(); chk_a("p0.hold", 8'h01, 3'd0, 1'b1, 1'b0);
        req_a = 8'h20;
        tick(); chk_a("p0.rel", 8'h00, 3'd0, 1'b0, 1'b0);

        // Reset mid-grant of requester 5; afterwards ptr=0 so 0 wins.
        req_a = 8'h21;
        tick(); chk_a("mid.g5", 8'h20, 3'd5, 1'b1, 1'b0);
        tick(); chk_a("mid.g5b", 8'h20, 3'd5, 1'b1, 1'b0);
        rst_a = 1'b1;
        tick(); chk_a("mid.rst", 8'h00, 3'd0, 1'b0, 1'b0);
        rst_a = 1'b0;
        tick(); chk_a("mid.p0", 8'h01, 3'd0, 1'b1, 1'b0);
        req_a = 8'h00;
        tick(); chk_a("mid.rel", 8'h00, 3'd0, 1'b0, 1'b0);

        // Timeout disabled: requester 4 keeps the grant through counter wrap.
        req_b = 8'h10;
        for (int c = 0; c < 300; c++) begin
            tick();
            chk($sformatf("nohold.c%0d.gnt", c), 32'(gnt_b), 32'h10);
            chk($sformatf("nohold.c%0d.to", c), 32'(to_b), 32'h0);
        end
        chk("nohold.idx", 32'(idx_b), 32'h4);
        req_b = 8'h00;
        tick();
        chk("nohold.rel.gnt", 32'(gnt_b), 32'h0);
        chk("nohold.rel.to", 32'(to_b), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
- Round-robin arbiter that shares one resource between 8 requesters.
- Selects the winning requester as a 3-bit index, then expands it to a one-hot grant through the team's 3-to-8 decoder.
- Holds each grant until the requester releases it, or until an optional hold timeout expires.
- Sits in front of any shared single-port resource (bus, memory port, ALU) in the datapath.

Parameters:
- MAX_HOLD, 16, maximum cycles a grant may be held (1..255); 0 disables the timeout.
- CNT_W, 8, width of the hold counter; must satisfy MAX_HOLD < 2**CNT_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  8  request vector; bit i = requester i.
- gnt  output  8  one-hot grant; all zero when no grant is active.
- gnt_idx  output  3  index of the current or most recent winner.
- gnt_valid  output  1  high while any grant is active.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Single clock domain, fully synchronous. Reset is synchronous and active-high.
- Reset values: state=IDLE, ptr=0, gnt=8'h00, gnt_idx=0, gnt_valid=0, timeout=0, hold_cnt=0.
- Internal ptr (3 bits) is the highest-priority index. Search order is ptr, ptr+1, ..., ptr+7, mod 8.
- IDLE state:
  - If req != 0 at a clock edge, latch the first set bit in search order into gnt_idx and move to GRANT.
  - Grant latency is therefore 1 cycle from req sampled high to gnt/gnt_valid high.
  - If req == 0, stay in IDLE.
- GRANT state:
  - gnt = decode(gnt_idx) and gnt_valid=1.
  - hold_cnt increments each GRANT cycle, starting from 0 on the first GRANT cycle.
- Release: if req[gnt_idx]==0 at an edge in GRANT:
  - state goes to IDLE and ptr <= gnt_idx+1 (7 wraps to 0).
  - hold_cnt is cleared and gnt drops in the next cycle.
- Timeout (MAX_HOLD != 0): if req[gnt_idx]==1 and hold_cnt==MAX_HOLD-1 at an edge:
  - perform the same transition as Release;
  - timeout is high for exactly the following cycle.
- A grant lasts at most MAX_HOLD cycles.
- There is always one IDLE cycle with gnt=0 between consecutive grants. No back-to-back grant handoff.
- gnt_idx holds its last value in IDLE. Consumers qualify it with gnt_valid.
- Requests from other requesters arriving during GRANT are ignored until IDLE; no preemption.
- A requester revoked by timeout that keeps req high is re-arbitrated normally. Because ptr has moved past it, it now has lowest priority.
- Simultaneous requests in IDLE: the requester nearest ptr in search order wins.
- Single requester: it wins regardless of ptr.
- rst asserted during GRANT: all outputs return to reset values at that edge and ptr returns to 0.
- Outputs are driven from registered state (gnt via the decoder from registered gnt_idx and state). No combinational path from req to outputs.

Decomposition:
- Shared package / include file arb_defs:
  - state localparams ST_IDLE=1'b0, ST_GRANT=1'b1;
  - NUM_REQ=8;
  - IDX_W=3.
- One sub-module instance: decoder_3_8 converts gnt_idx to one-hot.
  - gnt = gnt_valid ? dec_out : 8'h00.
- The rotating priority search (ptr-relative first-one) is a combinational function inside this module, not a separate module.

Test Plan:
- Reset, then req=8'h00 for 10 cycles -> gnt=0, gnt_valid=0, timeout=0 throughout.
- req=8'b0000_0100 held 3 cycles, then dropped -> gnt=8'h04 and gnt_idx=2 one cycle after req; gnt=0 the cycle after the release edge; ptr=3.
- req=8'hFF held continuously, MAX_HOLD=4 -> grant sequence idx 0,1,2,...,7,0. Each grant lasts 4 cycles, followed by a 1-cycle gap. timeout pulses once per grant.
- ptr=6 (set by a prior grant to 5), req=8'b0100_0001 -> idx 6 wins. After its release, req bit 0 still high -> idx 0 wins next.
- MAX_HOLD=0, req=8'h10 held 300 cycles -> gnt=8'h10 for all 300 cycles, no timeout pulse, hold_cnt wrap has no effect.
- rst asserted for 1 cycle mid-grant of idx 5 -> next cycle gnt=0, gnt_idx=0, gnt_valid=0. With req=8'h21 still high afterwards, idx 0 wins (ptr=0).
